ca_stream_packer: RTL

Downstream consumer of the 8-bit cellular-automaton pattern generator. Samples the CA output byte on enabled cycles, packs consecutive bytes into wider words, and buffers them in a small FIFO for a valid/ready consumer (BIST pattern sink or RNG client). Optionally detects the all-zero lock-up state, which is a fixed point of a null-boundary rule-90/150 CA, and requests a reseed.

---
 rtl/ca_pkg.sv | 12 +
 rtl/ca_pack_fifo.sv | 52 +++++
 rtl/ca_stream_packer.sv | 109 ++++++++++
 3 files changed

// File: rtl/ca_pkg.sv
// Shared constants and helpers for the CA stream packer.
package ca_pkg;

  localparam int CA_W       = 8;
  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  function automatic int packed_word_w(input int word_bytes);
    return word_bytes * CA_W;
  endfunction

endpackage

// File: rtl/ca_pack_fifo.sv
// Small synchronous FIFO; head word is read straight out of the storage registers.
// A push while full is accepted when a pop happens on the same edge.
module ca_pack_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ca_stream_packer.sv
// Packs sampled CA bytes LSB-first into words and queues them for a valid/ready sink.
// Define CA_PACK_LOCKUP_DET_EN to build the all-zero lock-up detector and reseed pulse.
module ca_stream_packer
  import ca_pkg::*;
#(
  parameter int WORD_BYTES  = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int LOCK_THRESH = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [CA_W-1:0]                     ca_in,
  input  logic                                ca_en,
  output logic [packed_word_w(WORD_BYTES)-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DROP_CNT_W-1:0]               drop_count,
  output logic                                reseed_req
);

  localparam int WW     = packed_word_w(WORD_BYTES);
  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  if (WORD_BYTES < 2 || WORD_BYTES > 8 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LOCK_THRESH < 1 || LOCK_THRESH > 15) begin : g_bad_cfg
    $error("ca_stream_packer: parameter out of range");
  end

  logic [LANE_W-1:0] lane;
  logic [WW-1:0]     asm_q;
  logic [WW-1:0]     word_next;
  logic              last_lane;
  logic              lock_hit;
  logic              push_req;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign last_lane = (lane == LANE_W'(WORD_BYTES - 1));

  // Completed word = held lanes plus the byte being sampled on this edge.
  always_comb begin
    word_next = asm_q;
    word_next[CA_W*lane +: CA_W] = ca_in;
  end

`ifdef CA_PACK_LOCKUP_DET_EN
  logic [3:0] zrun;
  logic       reseed_q;

  assign lock_hit   = ca_en && (ca_in == '0) && ((zrun + 4'd1) == 4'(LOCK_THRESH));
  assign reseed_req = reseed_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zrun     <= '0;
      reseed_q <= 1'b0;
    end else begin
      reseed_q <= lock_hit;
      if (ca_en) begin
        if (lock_hit || ca_in != '0) zrun <= '0;
        else                         zrun <= zrun + 4'd1;
      end
    end
  end
`else
  assign lock_hit   = 1'b0;
  assign reseed_req = 1'b0;
`endif

  // Handshake: a word transfers on any edge where out_valid and out_ready are both high;
  // out_valid never depends on out_ready, and the head word holds until transferred.
  assign pop      = out_valid && out_ready;
  assign push_req = ca_en && last_lane && !lock_hit;
  assign out_valid = !fifo_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane       <= '0;
      asm_q      <= '0;
      drop_count <= '0;
    end else begin
      if (lock_hit) begin
        lane  <= '0;
        asm_q <= '0;
      end else if (ca_en) begin
        asm_q[CA_W*lane +: CA_W] <= ca_in;
        lane <= last_lane ? '0 : lane + 1'b1;
      end
      if (push_req && fifo_full && !pop && drop_count != DROP_CNT_MAX)
        drop_count <= drop_count + 1'b1;
    end
  end

  ca_pack_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (word_next),
    .pop       (pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
